// File: rtl/sc_io_pkg.sv
// Shared types and constants for the io_dec_display output stage.
// Covers FSM states, segment codes and the pending-write payload.
package sc_io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;
    localparam logic [6:0]  SEG_ZERO  = 7'b1000000;
    localparam logic [31:0] DEC_MAX   = 32'd999999;

    // Active-low {g,f,e,d,c,b,a}; entry d sits at SEG_TABLE[d]
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef struct packed {
        logic        vld;
        logic [31:0] data;
    } wr_req_t;

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Codes 10..15 are not decimal digits and leave the display dark.
module seg7_dec
    import sc_io_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg_c
);

    always_comb begin
        o_seg_c = SEG_BLANK;
        if (i_bcd < 4'd10) begin
            o_seg_c = SEG_TABLE[i_bcd];
        end
    end

endmodule

// File: rtl/io_dec_display.sv
// CPU out_port value to six 7-segment digits via a sequential double-dabble engine.
// Optional leading-zero blanking on hex5..hex1: define IO_DEC_DISPLAY_LZ_BLANK_EN.
module io_dec_display
    import sc_io_pkg::*;
#(
    parameter int unsigned BIN_W  = 20,
    parameter int unsigned DIGITS = 6
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        ovf,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W);

`ifdef IO_DEC_DISPLAY_LZ_BLANK_EN
    localparam logic [6:0] HEX_RST_HI = SEG_BLANK;
`else
    localparam logic [6:0] HEX_RST_HI = SEG_ZERO;
`endif
    localparam logic [DIGITS-1:0][6:0] HEX_RST = {{(DIGITS-1){HEX_RST_HI}}, SEG_ZERO};

    state_t                  r_state;
    logic [BIN_W-1:0]        r_bin;
    logic [BCD_W-1:0]        r_bcd;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ovf_next;
    wr_req_t                 r_pend;
    logic                    r_busy;
    logic                    r_ovf;
    logic [DIGITS-1:0][6:0]  r_hex;

    state_t                  w_state_nxt;
    logic [BIN_W-1:0]        w_bin_nxt;
    logic [BCD_W-1:0]        w_bcd_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_ovf_next_nxt;
    wr_req_t                 w_pend_nxt;
    logic                    w_busy_nxt;
    logic                    w_ovf_nxt;
    logic [DIGITS-1:0][6:0]  w_hex_nxt;

    logic                    w_start;
    logic [31:0]             w_start_data;
    logic [BCD_W-1:0]        w_adj;
    logic [DIGITS-1:0][6:0]  w_seg;
    logic [DIGITS-1:0][6:0]  w_disp;

    // One decoder per digit, fed from the finished BCD register
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
        seg7_dec u_seg7_dec (
            .i_bcd   (r_bcd[4*g +: 4]),
            .o_seg_c (w_seg[g])
        );
    end

    // Add-3 correction applied to every nibble before each shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_disp = w_seg;
`ifdef IO_DEC_DISPLAY_LZ_BLANK_EN
        // Blank from the top down until the first non-zero digit; hex0 always lit
        begin
            logic v_lead;
            v_lead = 1'b1;
            for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
                v_lead = v_lead & (r_bcd[4*i +: 4] == 4'd0);
                if (v_lead) begin
                    w_disp[i] = SEG_BLANK;
                end
            end
        end
`endif
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bin_nxt      = r_bin;
        w_bcd_nxt      = r_bcd;
        w_cnt_nxt      = r_cnt;
        w_ovf_next_nxt = r_ovf_next;
        w_pend_nxt     = r_pend;
        w_ovf_nxt      = r_ovf;
        w_hex_nxt      = r_hex;
        w_start        = 1'b0;
        w_start_data   = wr_data;

        case (r_state)
            IDLE: begin
                if (wr_en) begin
                    w_start = 1'b1;
                end
            end
            CONV: begin
                if (wr_en) begin
                    w_pend_nxt = '{vld: 1'b1, data: wr_data};
                end
                {w_bcd_nxt, w_bin_nxt} = {w_adj[BCD_W-2:0], r_bin, 1'b0};
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(BIN_W - 1)) begin
                    w_state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                w_ovf_nxt = r_ovf_next;
                w_hex_nxt = r_ovf_next ? {DIGITS{SEG_DASH}} : w_disp;
                // A write on this very edge is the newest and supersedes any older pending one
                if (wr_en) begin
                    w_start        = 1'b1;
                    w_pend_nxt.vld = 1'b0;
                end else if (r_pend.vld) begin
                    w_start        = 1'b1;
                    w_start_data   = r_pend.data;
                    w_pend_nxt.vld = 1'b0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_start) begin
            w_state_nxt    = CONV;
            w_bin_nxt      = w_start_data[BIN_W-1:0];
            w_bcd_nxt      = '0;
            w_cnt_nxt      = '0;
            w_ovf_next_nxt = (w_start_data > DEC_MAX);
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_next <= 1'b0;
            r_pend     <= '0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
            r_hex      <= HEX_RST;
        end else begin
            r_state    <= w_state_nxt;
            r_bin      <= w_bin_nxt;
            r_bcd      <= w_bcd_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ovf_next <= w_ovf_next_nxt;
            r_pend     <= w_pend_nxt;
            r_busy     <= w_busy_nxt;
            r_ovf      <= w_ovf_nxt;
            r_hex      <= w_hex_nxt;
        end
    end

    assign busy = r_busy;
    assign ovf  = r_ovf;
    assign hex0 = r_hex[0];
    assign hex1 = r_hex[1];
    assign hex2 = r_hex[2];
    assign hex3 = r_hex[3];
    assign hex4 = r_hex[4];
    assign hex5 = r_hex[5];

endmodule

// File: tb/tb_io_dec_display.sv
// Scoreboard bench for io_dec_display: stimulus queues expected display updates,
// a monitor pops one on every change of {ovf, hex5..hex0} and checks value and cycle.
module tb_io_dec_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
`ifdef IO_DEC_DISPLAY_LZ_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = S0;
`endif

    // {hex5, hex4, hex3, hex2, hex1, hex0}
    localparam logic [41:0] D_RST    = {LZ, LZ, LZ, LZ, LZ, S0};
    localparam logic [41:0] D_123456 = {S1, S2, S3, S4, S5, S6};
    localparam logic [41:0] D_999999 = {S9, S9, S9, S9, S9, S9};
    localparam logic [41:0] D_DASH   = {SD, SD, SD, SD, SD, SD};
    localparam logic [41:0] D_7      = {LZ, LZ, LZ, LZ, LZ, S7};
    localparam logic [41:0] D_11     = {LZ, LZ, LZ, LZ, S1, S1};
    localparam logic [41:0] D_33     = {LZ, LZ, LZ, LZ, S3, S3};
    localparam logic [41:0] D_1      = {LZ, LZ, LZ, LZ, LZ, S1};
    localparam logic [41:0] D_555555 = {S5, S5, S5, S5, S5, S5};

    typedef struct {
        logic [41:0] disp;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    logic        clock   = 1'b0;
    logic        resetn  = 1'b0;
    logic        wr_en   = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic        busy;
    logic        ovf;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int unsigned cyc    = 0;
    int          n_cmp  = 0;
    int          n_err  = 0;
    logic        mon_en = 1'b0;
    logic [42:0] prev;
    exp_t        q[$];

    io_dec_display dut (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .busy    (busy),
        .ovf     (ovf),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3),
        .hex4    (hex4),
        .hex5    (hex5)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_disp(input logic [41:0] d, input logic o, input int unsigned c);
        q.push_back('{disp: d, ovf: o, cyc: c});
    endtask

    // Called at a negedge; drives so the write is sampled on edge e
    task automatic write_at(input logic [31:0] v, input int unsigned e);
        while (cyc + 1 < e) @(negedge clock);
        wr_en   = 1'b1;
        wr_data = v;
        @(negedge clock);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("wait_idle", 64'(busy), 64'(1'b0));
    endtask

    // Monitor: every visible change of the display state must match the next queued entry
    initial begin
        logic [42:0] cur;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                cur = {ovf, hex5, hex4, hex3, hex2, hex1, hex0};
                if (cur != prev) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_change: got %h with nothing queued (cycle %0d)", cur, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("display", 64'(cur), 64'({e.ovf, e.disp}));
                        chk("update_cycle", 64'(cyc), 64'(e.cyc));
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        int unsigned c;

        repeat (3) @(negedge clock);
        chk("rst_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(D_RST));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_ovf", 64'(ovf), 64'(1'b0));
        resetn = 1'b1;
        @(negedge clock);
        prev   = {1'b0, D_RST};
        mon_en = 1'b1;

        // 123456: busy across edges k..k+20, display and idle after edge k+21
        k = cyc + 1;
        expect_disp(D_123456, 1'b0, k + 21);
        write_at(32'd123456, k);
        for (int i = 0; i < 21; i++) begin
            chk("busy_conv", 64'(busy), 64'(1'b1));
            @(negedge clock);
        end
        chk("busy_done", 64'(busy), 64'(1'b0));

        // Largest legal value, then the first overflowing one
        k = cyc + 1;
        expect_disp(D_999999, 1'b0, k + 21);
        write_at(32'd999999, k);
        wait_idle(40);
        k = cyc + 1;
        expect_disp(D_DASH, 1'b1, k + 21);
        write_at(32'd1000000, k);
        wait_idle(40);
        chk("ovf_set", 64'(ovf), 64'(1'b1));

        // Single digit: leading positions zero or blank
        k = cyc + 1;
        expect_disp(D_7, 1'b0, k + 21);
        write_at(32'd7, k);
        wait_idle(40);
        chk("ovf_clear", 64'(ovf), 64'(1'b0));

        // 11 converts; 22 is overwritten by 33 while pending; 33 restarts on the UPDATE edge
        k = cyc + 1;
        expect_disp(D_11, 1'b0, k + 21);
        expect_disp(D_33, 1'b0, k + 42);
        write_at(32'd11, k);
        write_at(32'd22, k + 3);
        write_at(32'd33, k + 5);
        while (cyc < k + 42) begin
            chk("busy_chain", 64'(busy), 64'(1'b1));
            @(negedge clock);
        end
        chk("busy_chain_end", 64'(busy), 64'(1'b0));

        // Write landing on the UPDATE edge of the previous conversion is kept
        k = cyc + 1;
        expect_disp(D_1, 1'b0, k + 21);
        expect_disp(D_555555, 1'b0, k + 42);
        write_at(32'd1, k);
        write_at(32'd555555, k + 21);
        chk("busy_restart", 64'(busy), 64'(1'b1));
        wait_idle(60);

        // Reset in the middle of a conversion leaves no trace
        k = cyc + 1;
        write_at(32'd654321, k);
        while (cyc < k + 10) @(negedge clock);
        #2;
        resetn = 1'b0;
        c = cyc;
        expect_disp(D_RST, 1'b0, c + 1);
        #1;
        chk("abort_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(D_RST));
        chk("abort_busy", 64'(busy), 64'(1'b0));
        chk("abort_ovf", 64'(ovf), 64'(1'b0));
        @(negedge clock);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (30) @(negedge clock);
        chk("post_abort_busy", 64'(busy), 64'(1'b0));
        chk("post_abort_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(D_RST));

        repeat (5) @(negedge clock);
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
